// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment capture block: the active-low segment
// codes for digits 0-9 and blank (bit 6 = a ... bit 0 = g), the BCD values
// reported for blank and unrecognised patterns, and the frame FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_pattern_encoder.sv
// seg7_pattern_encoder
// Combinational inverse of the team BCD-to-7-segment decoder.
// Ports:
//   pattern  in  7  active-low segment pattern (bit 6 = a ... bit 0 = g)
//   bcd      out 4  recovered digit, 4'hF for blank, 4'hE for unknown
//   blank    out 1  pattern was all segments off
//   err      out 1  pattern is not a digit and not blank
module seg7_pattern_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       err
);

    always_comb begin
        bcd   = BCD_ERR;
        blank = 1'b0;
        err   = 1'b1;
        case (pattern)
            SEG_0:     begin bcd = 4'd0; err = 1'b0; end
            SEG_1:     begin bcd = 4'd1; err = 1'b0; end
            SEG_2:     begin bcd = 4'd2; err = 1'b0; end
            SEG_3:     begin bcd = 4'd3; err = 1'b0; end
            SEG_4:     begin bcd = 4'd4; err = 1'b0; end
            SEG_5:     begin bcd = 4'd5; err = 1'b0; end
            SEG_6:     begin bcd = 4'd6; err = 1'b0; end
            SEG_7:     begin bcd = 4'd7; err = 1'b0; end
            SEG_8:     begin bcd = 4'd8; err = 1'b0; end
            SEG_9:     begin bcd = 4'd9; err = 1'b0; end
            SEG_BLANK: begin bcd = BCD_BLANK; blank = 1'b1; err = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture
// Monitors a multiplexed active-low 7-segment display bus and recovers the
// displayed digits, presenting each complete frame on a valid/ready handshake.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   seg_n         active-low segment lines (bit 6 = a ... bit 0 = g)
//   an_n          active-low digit strobes, an_n[i] low selects digit i
//   frame_bcd     captured digits, digit i at [4i+3:4i]
//   frame_blank   per-digit blank flags
//   frame_err     per-digit unrecognised-pattern flags
//   frame_valid   frame available
//   frame_ready   consumer accepts the frame
//   overrun       sticky: a complete frame was dropped while one was pending
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    // The counter holds (identical samples so far - 1); the capture fires on
    // the sample that brings it to STABLE_CYCLES-1 and then it saturates
    // there, so a held pattern is captured exactly once.
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0] sync1_q, sync1_d;
    logic [SW-1:0] sync2_q, sync2_d;
    logic [SW-1:0] prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d;
    logic [NUM_DIGITS-1:0]   work_blank_q, work_blank_d;
    logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;

    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] frame_bcd_q, frame_bcd_d;
    logic [NUM_DIGITS-1:0]   frame_blank_q, frame_blank_d;
    logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic [NUM_DIGITS-1:0] cur_an;
    logic [6:0]            cur_seg;
    logic                  strobe_ok;
    logic                  same;
    logic                  capture;
    logic [3:0]            enc_bcd;
    logic                  enc_blank;
    logic                  enc_err;
    logic                  seen_full;
    logic                  accept;

    seg7_pattern_encoder u_enc (
        .pattern (cur_seg),
        .bcd     (enc_bcd),
        .blank   (enc_blank),
        .err     (enc_err)
    );

    // Synchroniser and stability qualification
    always_comb begin
        sync1_d   = {an_n, seg_n};
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        cur_an    = sync2_q[SW-1:7];
        cur_seg   = sync2_q[6:0];
        strobe_ok = $onehot(~cur_an);
        same      = (sync2_q == prev_q);
        capture   = strobe_ok && same && (cnt_q == CNT_FIRE);

        cnt_d = cnt_q;
        if (!strobe_ok || !same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Working registers: the strobe is one-hot when capture is set, so the
    // inverted strobe selects exactly the digit being written.
    always_comb begin
        work_bcd_d   = work_bcd_q;
        work_blank_d = work_blank_q;
        work_err_d   = work_err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && !cur_an[i]) begin
                work_bcd_d[4*i +: 4] = enc_bcd;
                work_blank_d[i]      = enc_blank;
                work_err_d[i]        = enc_err;
            end
        end
    end

    // Frame FSM
    always_comb begin
        state_d       = state_q;
        frame_bcd_d   = frame_bcd_q;
        frame_blank_d = frame_blank_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q;
        seen_d        = seen_q;
        seen_full     = &seen_q;
        accept        = (state_q == PRESENT) && frame_ready;

        case (state_q)
            COLLECT: begin
                if (seen_full) begin
                    frame_bcd_d   = work_bcd_q;
                    frame_blank_d = work_blank_q;
                    frame_err_d   = work_err_q;
                    seen_d        = '0;
                    state_d       = PRESENT;
                end
            end
            PRESENT: begin
                if (seen_full) begin
                    // A full set arriving while the pending frame is taken in
                    // the same cycle replaces it; otherwise the new set is lost.
                    if (accept) begin
                        frame_bcd_d   = work_bcd_q;
                        frame_blank_d = work_blank_q;
                        frame_err_d   = work_err_q;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    seen_d = '0;
                end else if (accept) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        // A capture landing on the clearing cycle belongs to the next frame.
        if (capture) begin
            seen_d = seen_d | ~cur_an;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            state_q       <= COLLECT;
            frame_bcd_q   <= '0;
            frame_blank_q <= '0;
            frame_err_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            state_q       <= state_d;
            frame_bcd_q   <= frame_bcd_d;
            frame_blank_q <= frame_blank_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Working registers are only read once every seen bit has been rewritten.
    always_ff @(posedge clk) begin
        work_bcd_q   <= work_bcd_d;
        work_blank_q <= work_blank_d;
        work_err_q   <= work_err_d;
    end

    assign frame_bcd   = frame_bcd_q;
    assign frame_blank = frame_blank_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = (state_q == PRESENT);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;
    logic [4*ND-1:0] frame_bcd;
    logic [ND-1:0] frame_blank;
    logic [ND-1:0] frame_err;
    logic          frame_valid;
    logic          frame_ready;
    logic          overrun;

    always #5 clk = ~clk;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_bcd   (frame_bcd),
        .frame_blank (frame_blank),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    // Reference model: digits are recognised on the pins themselves by
    // counting how many consecutive cycles a pin value has been driven.
    logic [6:0]  code_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                   7'b0000000, 7'b0000100};
    logic [10:0] run_val = 11'h7FF;
    int          run_len = 0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_err = '0;
    logic [3:0]  m_seen = '0;
    bit          m_pending = 0;
    bit          m_overrun = 0;
    frame_t      exp_q[$];

    int     n_xfer = 0;
    int     n_valid_cycles = 0;
    frame_t last_xfer = '0;
    bit     hold_chk = 0;
    frame_t held = '0;

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] b,
                                         output logic bl, output logic er);
        b = 4'hE; bl = 1'b0; er = 1'b1;
        if (s == 7'h7F) begin
            b = 4'hF; bl = 1'b1; er = 1'b0;
        end else begin
            for (int d = 0; d < 10; d++)
                if (s == code_tab[d]) begin b = d[3:0]; er = 1'b0; end
        end
    endfunction

    task automatic model_cycle(input logic [3:0] an, input logic [6:0] seg);
        logic [3:0] b;
        logic bl, er;
        int idx;
        if ({an, seg} == run_val) run_len++;
        else begin run_val = {an, seg}; run_len = 1; end
        if (run_len == SC && $countones(~an) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
            model_decode(seg, b, bl, er);
            m_bcd[4*idx +: 4] = b;
            m_blank[idx] = bl;
            m_err[idx] = er;
            m_seen[idx] = 1'b1;
            if (&m_seen) begin
                m_seen = '0;
                if (m_pending) m_overrun = 1;
                else begin
                    exp_q.push_back({m_bcd, m_blank, m_err});
                    m_pending = 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        run_val = 11'h7FF; run_len = 0;
        m_seen = '0; m_pending = 0; m_overrun = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) begin
            @(posedge clk); #2;
            an_n = an; seg_n = seg;
            model_cycle(an, seg);
        end
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] seg, input int n);
        logic [3:0] one;
        one = 4'b0001 << idx;
        drive(~one, seg, n);
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h7F, n);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input int hold);
        drive_digit(0, s0, hold);
        drive_digit(1, s1, hold);
        drive_digit(2, s2, hold);
        drive_digit(3, s3, hold);
    endtask

    // Transfer monitor and hold-stability check, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk <= 0;
        end else begin
            frame_t cur;
            frame_t e;
            cur = {frame_bcd, frame_blank, frame_err};
            if (frame_valid) n_valid_cycles++;
            if (hold_chk && frame_valid) begin
                checks++;
                if (cur !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got %h required %h", cur, held);
                end
            end
            hold_chk <= frame_valid && !frame_ready;
            held <= cur;
            if (frame_valid && frame_ready) begin
                n_xfer++;
                last_xfer = cur;
                m_pending = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got %h required no frame", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL xfer_frame: got %h required %h", cur, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; an_n = 4'hF; seg_n = 7'h7F; frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", frame_valid); end
        checks++; if (frame_bcd !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h required 0000", frame_bcd); end
        checks++; if (frame_blank !== 4'h0) begin errors++; $display("FAIL reset_blank: got %b required 0000", frame_blank); end
        checks++; if (frame_err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b required 0000", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        #1 rst = 1'b0;
        idle(3);
    endtask

    task automatic test_scan_basic();
        int x0;
        frame_ready = 1'b1;
        x0 = n_xfer;
        scan(code_tab[1], code_tab[2], code_tab[3], code_tab[4], 8);
        idle(8);
        checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL basic_count: got %0d required 1", n_xfer - x0); end
        checks++; if (last_xfer !== {16'h4321, 4'b0000, 4'b0000}) begin errors++; $display("FAIL basic_frame: got %h required %h", last_xfer, {16'h4321, 8'h00}); end
    endtask

    task automatic test_short_hold();
        int v0, x0;
        v0 = n_valid_cycles; x0 = n_xfer;
        scan(code_tab[1], code_tab[2], code_tab[3], code_tab[4], 3);
        idle(10);
        checks++; if (n_valid_cycles != v0) begin errors++; $display("FAIL short_valid: got %0d valid cycles required 0", n_valid_cycles - v0); end
        checks++; if (n_xfer != x0) begin errors++; $display("FAIL short_xfer: got %0d required 0", n_xfer - x0); end
    endtask

    task automatic test_blank_err();
        int x0;
        x0 = n_xfer;
        scan(code_tab[7], code_tab[9], 7'b1111111, 7'b1111110, 8);
        idle(8);
        checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL blankerr_count: got %0d required 1", n_xfer - x0); end
        checks++; if (last_xfer !== {16'hEF97, 4'b0100, 4'b1000}) begin errors++; $display("FAIL blankerr_frame: got %h required %h", last_xfer, {16'hEF97, 4'b0100, 4'b1000}); end
    endtask

    task automatic test_multi_strobe();
        int x0;
        x0 = n_xfer;
        drive_digit(0, code_tab[5], 8);
        drive_digit(1, code_tab[6], 8);
        drive(4'b1100, code_tab[8], 10);
        idle(4);
        checks++; if (n_xfer != x0) begin errors++; $display("FAIL multi_early: got %0d frames required 0", n_xfer - x0); end
        drive_digit(2, code_tab[0], 8);
        drive_digit(3, code_tab[9], 8);
        idle(8);
        checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL multi_count: got %0d required 1", n_xfer - x0); end
        checks++; if (last_xfer.bcd !== 16'h9065) begin errors++; $display("FAIL multi_frame: got %h required 9065", last_xfer.bcd); end
    endtask

    task automatic test_overrun();
        int x0;
        frame_ready = 1'b0;
        x0 = n_xfer;
        scan(code_tab[1], code_tab[2], code_tab[3], code_tab[4], 8);
        scan(code_tab[5], code_tab[6], code_tab[7], code_tab[8], 8);
        idle(8);
        #1;
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b required 1", frame_valid); end
        checks++; if (frame_bcd !== 16'h4321) begin errors++; $display("FAIL ovr_held: got %h required 4321", frame_bcd); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        checks++; if (n_xfer != x0) begin errors++; $display("FAIL ovr_noxfer: got %0d required 0", n_xfer - x0); end
        @(posedge clk); #2 frame_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop: got %b required 0", frame_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
        checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL ovr_xfer: got %0d required 1", n_xfer - x0); end
        idle(3);
    endtask

    task automatic test_reset_midframe();
        int x0;
        frame_ready = 1'b1;
        drive_digit(0, code_tab[1], 8);
        drive_digit(1, code_tab[2], 8);
        drive_digit(2, code_tab[3], 8);
        idle(2);
        #1 rst = 1'b1;
        model_reset();
        #14 rst = 1'b0;
        x0 = n_xfer;
        scan(code_tab[5], code_tab[6], code_tab[7], code_tab[8], 8);
        idle(8);
        checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL rstmid_count: got %0d required 1", n_xfer - x0); end
        checks++; if (last_xfer.bcd !== 16'h8765) begin errors++; $display("FAIL rstmid_frame: got %h required 8765", last_xfer.bcd); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b required 0", overrun); end
    endtask

    task automatic test_random();
        logic [3:0] bad_an [4] = '{4'b1111, 4'b0011, 4'b1010, 4'b0000};
        logic [6:0] seg;
        frame_ready = 1'b1;
        repeat (60) begin
            int r, hold;
            r = $urandom_range(0, 9);
            hold = $urandom_range(2, 9);
            case ($urandom_range(0, 9))
                0:       seg = 7'h7F;
                1:       seg = 7'($urandom);
                default: seg = code_tab[$urandom_range(0, 9)];
            endcase
            if (r < 8) drive_digit($urandom_range(0, 3), seg, hold);
            else       drive(bad_an[$urandom_range(0, 3)], seg, hold);
        end
        idle(12);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending: got %0d frames outstanding required 0", exp_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun: got %b required 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_short_hold();
        test_blank_err();
        test_multi_strobe();
        test_random();
        test_overrun();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
